// File: rtl/decap_packet.sv
// Reassembles a 1034-bit DFX word from 19 Aurora link words.
// Words carry a router id and sequence number; mismatches resync or abort.
module decap_packet #(
   parameter int         DATA_WIDTH        = 1024,
   parameter int         ADDR_WIDTH        = 10,
   parameter int         NUMBER_PACKET     = 19,
   parameter int         AURORA_DATA_WIDTH = 64,
   parameter logic [1:0] MY_ROUTER_ID      = 2'b00
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [AURORA_DATA_WIDTH-1:0]        data_out_port,
   input  logic                                data_out_valid,
   output logic                                in_ready,
   output logic [DATA_WIDTH+ADDR_WIDTH-1:0]    data_dfx_recv,
   output logic                                dfx_valid,
   input  logic                                dfx_ready,
   output logic                                seq_err,
   output logic [15:0]                         frames_rx
);

   localparam int DFX_W         = DATA_WIDTH + ADDR_WIDTH;
   localparam int HEADER_WIDTH  = 9;
   localparam int PAYLOAD_WIDTH = AURORA_DATA_WIDTH - HEADER_WIDTH;
   localparam logic [4:0] LAST_SEQ = 5'(NUMBER_PACKET - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [PAYLOAD_WIDTH-1:0] payload;
   logic [1:0]               router_id;
   logic [4:0]               seq;
   logic                     unused_ttl;

   logic             accept;
   logic             seq_match;
   logic [4:0]       expected;
   logic [10:0]      slice_off;
   logic [DFX_W-1:0] frame_buf;
   logic [DFX_W-1:0] payload_wide;
   logic [DFX_W-1:0] slice_mask;
   logic [DFX_W-1:0] buf_written;

   assign payload    = data_out_port[AURORA_DATA_WIDTH-1:HEADER_WIDTH];
   assign router_id  = data_out_port[8:7];
   assign seq        = data_out_port[6:2];
   // ttl plays no part in reassembly
   assign unused_ttl = ^data_out_port[1:0];

   assign accept    = data_out_valid && in_ready
                      && (router_id == MY_ROUTER_ID);
   assign seq_match = (seq == expected);
   assign slice_off = 11'(seq) * 11'(PAYLOAD_WIDTH);

   // Place the payload at its slice; shifting past the top truncates word 18
   always_comb begin
      payload_wide = '0;
      slice_mask   = '0;
      payload_wide[PAYLOAD_WIDTH-1:0] = payload;
      slice_mask[PAYLOAD_WIDTH-1:0]   = '1;
      buf_written = (frame_buf & ~(slice_mask << slice_off))
                    | (payload_wide << slice_off);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept && seq == 5'd0) state_nx = COLLECT;
         end
         COLLECT: begin
            if (accept) begin
               if (seq_match) begin
                  if (seq == LAST_SEQ) state_nx = DONE;
               end else if (seq != 5'd0) begin
                  state_nx = IDLE;
               end
            end
         end
         DONE: begin
            if (dfx_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs follow the state directly
   always_comb begin
      in_ready  = (state != DONE);
      dfx_valid = (state == DONE);
   end

   // Reassembly buffer, sequence tracking, error pulse and frame count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expected      <= '0;
         frame_buf     <= '0;
         data_dfx_recv <= '0;
         seq_err       <= 1'b0;
         frames_rx     <= '0;
      end else begin
         seq_err <= 1'b0;
         if (accept) begin
            unique case (state)
               IDLE: begin
                  if (seq == 5'd0) begin
                     frame_buf <= payload_wide;
                     expected  <= 5'd1;
                  end
               end
               COLLECT: begin
                  if (seq_match) begin
                     frame_buf <= buf_written;
                     if (seq == LAST_SEQ) begin
                        data_dfx_recv <= buf_written;
                        expected      <= 5'd0;
                     end else begin
                        expected <= expected + 5'd1;
                     end
                  end else begin
                     seq_err <= 1'b1;
                     if (seq == 5'd0) begin
                        frame_buf <= payload_wide;
                        expected  <= 5'd1;
                     end else begin
                        frame_buf <= '0;
                        expected  <= 5'd0;
                     end
                  end
               end
               default: ;
            endcase
         end
         if (state == DONE && dfx_ready)
            frames_rx <= frames_rx + 16'd1;
      end
   end

endmodule

// File: tb/tb_decap_packet.sv
// Scoreboard bench for decap_packet: expected frames are queued by the
// stimulus and checked by a monitor at each dfx_valid/dfx_ready handshake.
module tb_decap_packet;

   localparam int DW = 1034;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [63:0]   data_out_port;
   logic          data_out_valid;
   logic          in_ready;
   logic [DW-1:0] data_dfx_recv;
   logic          dfx_valid;
   logic          dfx_ready;
   logic          seq_err;
   logic [15:0]   frames_rx;

   int asserts    = 0;
   int fails      = 0;
   int err_seen   = 0;
   int err_exp    = 0;
   int exp_frames = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_exp;
   logic [54:0]   pay[19];
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   decap_packet dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_out_port  (data_out_port),
      .data_out_valid (data_out_valid),
      .in_ready       (in_ready),
      .data_dfx_recv  (data_dfx_recv),
      .dfx_valid      (dfx_valid),
      .dfx_ready      (dfx_ready),
      .seq_err        (seq_err),
      .frames_rx      (frames_rx)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_frame(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
      logic [DW-1:0] a;
      logic [DW-1:0] e;
      int bad;
      asserts++;
      if (act !== exp) begin
         fails++;
         bad = -1;
         for (int k = 18; k >= 0; k--) begin
            a = act >> (k * 55);
            e = exp >> (k * 55);
            if (a[54:0] !== e[54:0]) bad = k;
         end
         a = act >> (bad * 55);
         e = exp >> (bad * 55);
         $display("FAIL %s: slice %0d got %0h expected %0h",
                  name, bad, a[54:0], e[54:0]);
      end
   endtask

   // Expected frame written slice by slice; word 18 keeps only 44 bits
   function automatic logic [DW-1:0] build();
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < 18; k++) r[k*55 +: 55] = pay[k];
      r[990 +: 44] = pay[18][43:0];
      return r;
   endfunction

   task automatic send(input logic [1:0] id, input logic [4:0] sq,
                       input logic [54:0] p);
      int n;
      data_out_port  = {p, id, sq, 2'b10};
      data_out_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         asserts++;
         fails++;
         $display("FAIL send_timeout: in_ready stuck at 0");
      end
      @(posedge clk); #1;
      data_out_valid = 1'b0;
   endtask

   task automatic fill(input logic [10:0] hi, input logic [43:0] base);
      for (int k = 0; k < 19; k++) pay[k] = {hi, base + 44'(k + 1)};
      last_exp = build();
   endtask

   task automatic send_frame(input logic [10:0] hi, input logic [43:0] base);
      fill(hi, base);
      exp_q.push_back(last_exp);
      for (int k = 0; k < 19; k++) send(2'b00, 5'(k), pay[k]);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_dfx_valid"}, 64'(dfx_valid), 64'd0);
      chk({tag, "_seq_err"}, 64'(seq_err), 64'd0);
      chk({tag, "_frames_rx"}, 64'(frames_rx), 64'd0);
      chk_frame({tag, "_data"}, data_dfx_recv, '0);
   endtask

   // Monitor: error pulse count, hold stability and handshake scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (seq_err) err_seen++;
         if (dfx_valid && prev_hold)
            chk_frame("hold_data", data_dfx_recv, prev_data);
         if (dfx_valid && dfx_ready) begin
            chk("frames_rx_pre", 64'(frames_rx), 64'(exp_frames));
            if (exp_q.size() == 0) begin
               asserts++;
               fails++;
               $display("FAIL unexpected_frame: got frame, expected none");
            end else begin
               chk_frame("frame", data_dfx_recv, exp_q.pop_front());
            end
            exp_frames++;
         end
      end
      prev_hold = dfx_valid && !dfx_ready;
      prev_data = data_dfx_recv;
   end

   initial begin
      rst_n          = 1'b0;
      data_out_port  = '0;
      data_out_valid = 1'b0;
      dfx_ready      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // In-order frame, payload k+1, consumer always ready
      send_frame(11'h000, 44'h0);
      chk("t27_valid", 64'(dfx_valid), 64'd1);
      chk("t27_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("t27_valid_drop", 64'(dfx_valid), 64'd0);
      chk("t27_frames", 64'(frames_rx), 64'd1);

      // Back-pressure for 5 cycles, top payload bits exercise truncation
      dfx_ready = 1'b0;
      send_frame(11'h7FF, 44'h100);
      for (int i = 0; i < 5; i++) begin
         chk("t28_valid", 64'(dfx_valid), 64'd1);
         chk("t28_in_ready", 64'(in_ready), 64'd0);
         chk_frame("t28_data", data_dfx_recv, last_exp);
         data_out_port  = {55'h1234, 2'b00, 5'd0, 2'b00};
         data_out_valid = 1'b1;
         @(posedge clk); #1;
      end
      data_out_valid = 1'b0;
      chk_frame("t28_data_end", data_dfx_recv, last_exp);
      dfx_ready = 1'b1;
      @(posedge clk); #1;
      chk("t28_valid_drop", 64'(dfx_valid), 64'd0);
      chk("t28_frames", 64'(frames_rx), 64'd2);

      // Gap in sequence aborts to idle
      send(2'b00, 5'd0, 55'h10);
      send(2'b00, 5'd1, 55'h11);
      send(2'b00, 5'd2, 55'h12);
      send(2'b00, 5'd5, 55'h15);
      err_exp++;
      chk("t29_err_pulse", 64'(seq_err), 64'd1);
      @(posedge clk); #1;
      chk("t29_err_clear", 64'(seq_err), 64'd0);
      chk("t29_in_ready", 64'(in_ready), 64'd1);
      send(2'b00, 5'd1, 55'h99);
      chk("t29_idle_discard", 64'(seq_err), 64'd0);
      send_frame(11'h000, 44'h200);
      @(posedge clk); #1;

      // Restart on seq 0 mid-frame
      for (int k = 0; k <= 6; k++) send(2'b00, 5'(k), 55'h3000 + 55'(k));
      err_exp++;
      send_frame(11'h155, 44'h300);
      @(posedge clk); #1;

      // Other router's words interleaved must be ignored
      fill(11'h2AA, 44'h400);
      exp_q.push_back(last_exp);
      for (int k = 0; k < 19; k++) begin
         send(2'b00, 5'(k), pay[k]);
         if (k < 18)
            send(2'b01, (k % 2 == 0) ? 5'(k + 1) : 5'd0, 55'h7F_FFFF);
      end
      @(posedge clk); #1;
      chk("t31_frames", 64'(frames_rx), 64'd5);

      // Reset mid-frame abandons everything
      for (int k = 0; k <= 10; k++) send(2'b00, 5'(k), 55'h5000 + 55'(k));
      rst_n      = 1'b0;
      exp_frames = 0;
      #1;
      chk_reset_vals("t32_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_frame(11'h000, 44'h600);
      chk("t32_valid", 64'(dfx_valid), 64'd1);
      @(posedge clk); #1;
      chk("t32_frames", 64'(frames_rx), 64'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("seq_err_count", 64'(err_seen), 64'(err_exp));
      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, fails);
      $finish;
   end

endmodule
